// File: rtl/dice_pkg.sv
// dice_pkg: shared types and widths for the dice button front end.
// Holds the debounce FSM state encoding and the press counter width.
package dice_pkg;
    localparam int PRESS_CNT_W = 8;
    // Bit 1 of the encoding is high exactly in the states where button=1.
    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchroniser for an asynchronous single-bit input.
// Ports: clk (clock), rst (async active-low reset), d (async input),
//        q (synchronised output, last stage of the chain).
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] r;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r <= '0;
        else      r <= {r[STAGES-2:0], d};
    end
    assign q = r[STAGES-1];
endmodule

// File: rtl/dice_button_conditioner.sv
// dice_button_conditioner: synchronises and debounces the dice push-button.
// Ports: clk (clock), rst (async active-low reset), button_raw (bouncing input),
//        button (debounced level), press_pulse / release_pulse (one-cycle events),
//        press_count (accepted presses, wraps), long_press (held indicator).
// Build option: define DICE_LONG_PRESS_EN to build the long-press detector;
//        otherwise long_press is tied to 0.
module dice_button_conditioner
    import dice_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   button_raw,
    output logic                   button,
    output logic                   press_pulse,
    output logic                   release_pulse,
    output logic [PRESS_CNT_W-1:0] press_count,
    output logic                   long_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
        $error("dice_button_conditioner: parameter out of range");
    end

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          btn_s, press_ev, release_ev;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_raw),
        .q   (btn_s)
    );

    // cnt only advances while below DEBOUNCE_CYCLES, so it saturates by construction.
    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: if (btn_s) begin
                nxt     = PRESS_WAIT;
                cnt_nxt = CW'(1);
            end
            PRESS_WAIT: if (!btn_s) begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                nxt     = PRESSED;
                cnt_nxt = '0;
            end else cnt_nxt = cnt + 1'b1;
            PRESSED: if (!btn_s) begin
                nxt     = RELEASE_WAIT;
                cnt_nxt = CW'(1);
            end
            RELEASE_WAIT: if (btn_s) begin
                nxt     = PRESSED;
                cnt_nxt = '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end else cnt_nxt = cnt + 1'b1;
            default: begin
                nxt     = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    assign press_ev   = (state == PRESS_WAIT) && (nxt == PRESSED);
    assign release_ev = (state == RELEASE_WAIT) && (nxt == IDLE);

    // Outputs are registered from the next state so they change on the same
    // edge the FSM enters PRESSED / IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            button        <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= nxt;
            cnt           <= cnt_nxt;
            button        <= (nxt == PRESSED) || (nxt == RELEASE_WAIT);
            press_pulse   <= press_ev;
            release_pulse <= release_ev;
            if (press_ev) press_count <= press_count + 1'b1;
        end
    end

`ifdef DICE_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    logic [LW-1:0] lcnt;
    logic          held, held_nxt;
    assign held     = (state == PRESSED) || (state == RELEASE_WAIT);
    assign held_nxt = (nxt == PRESSED) || (nxt == RELEASE_WAIT);
    // long_press sets on the edge lcnt reaches LONG_CYCLES and drops on the
    // edge the FSM returns to IDLE (same edge as release_pulse).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lcnt       <= '0;
            long_press <= 1'b0;
        end else begin
            lcnt       <= !held ? '0 : (lcnt == LW'(LONG_CYCLES)) ? lcnt : lcnt + 1'b1;
            long_press <= held_nxt && (long_press || (held && lcnt == LW'(LONG_CYCLES - 1)));
        end
    end
`else
    assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_dice_button_conditioner.sv
// tb_dice_button_conditioner: directed bench for the dice button conditioner
// with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, 10 ns clock.
module tb_dice_button_conditioner;
    logic       clk = 1'b0;
    logic       rst;
    logic       button_raw;
    logic       button, press_pulse, release_pulse, long_press;
    logic [7:0] press_count;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] n_press = 8'd0;
`ifdef DICE_LONG_PRESS_EN
    localparam logic LP = 1'b1;
`else
    localparam logic LP = 1'b0;
`endif

    dice_button_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .button_raw    (button_raw),
        .button        (button),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .press_count   (press_count),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_quiet();
        button_raw = 1'b1;
        repeat (8) step();
        button_raw = 1'b0;
        repeat (10) step();
        n_press++;
    endtask

    initial begin
        // 1: reset held with button pressed, then qualification after release
        rst = 1'b0;
        button_raw = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_button", button, 0);
            chk("rst_count", press_count, 0);
            chk("rst_pulses", {press_pulse, release_pulse, long_press}, 0);
        end
        rst = 1'b1;
        repeat (6) step();
        chk("s1_button_e6", button, 0);
        step();
        n_press++;
        chk("s1_button_e7", button, 1);
        chk("s1_press_pulse", press_pulse, 1);
        chk("s1_count", press_count, n_press);
        step();
        chk("s1_press_pulse_off", press_pulse, 0);
        button_raw = 1'b0;
        repeat (6) step();
        chk("s1_rel_e6", button, 1);
        step();
        chk("s1_rel_e7", button, 0);
        chk("s1_release_pulse", release_pulse, 1);
        step();
        chk("s1_release_pulse_off", release_pulse, 0);
        repeat (3) step();

        // 2: 3-cycle glitch is rejected
        button_raw = 1'b1;
        repeat (3) step();
        button_raw = 1'b0;
        for (int k = 4; k <= 12; k++) begin
            step();
            chk("s2_button", button, 0);
            chk("s2_press_pulse", press_pulse, 0);
            chk("s2_count", press_count, n_press);
        end

        // 3: clean press held 20 cycles, then released
        button_raw = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 7) n_press++;
            chk("s3_button", button, k >= 7);
            chk("s3_press_pulse", press_pulse, k == 7);
            chk("s3_long_press", long_press, LP && k >= 17);
        end
        chk("s3_count", press_count, n_press);
        button_raw = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("s3_rel_button", button, k < 7);
            chk("s3_release_pulse", release_pulse, k == 7);
            chk("s3_rel_long_press", long_press, LP && k < 7);
        end

        // 4: release bounce low 2, high 1, then stable low
        button_raw = 1'b1;
        repeat (10) step();
        n_press++;
        chk("s4_pressed", button, 1);
        button_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 2) button_raw = 1'b1;
            if (k == 3) button_raw = 1'b0;
            chk("s4_button", button, k < 10);
            chk("s4_release_pulse", release_pulse, k == 10);
        end
        chk("s4_count", press_count, n_press);

        // 5: press counter wrap 255 -> 0
        while (n_press != 8'd255) press_quiet();
        chk("s5_count_255", press_count, 255);
        button_raw = 1'b1;
        repeat (7) step();
        n_press++;
        chk("s5_count_wrap", press_count, 0);
        chk("s5_wrap_pulse", press_pulse, 1);
        chk("s5_wrap_expect", {24'd0, n_press}, 0);
        button_raw = 1'b0;
        repeat (10) step();

        // 6: async reset mid-hold, then requalification as a new press
        button_raw = 1'b1;
        repeat (12) step();
        chk("s6_held", button, 1);
        #3 rst = 1'b0;
        #1;
        chk("s6_async_button", button, 0);
        chk("s6_async_count", press_count, 0);
        chk("s6_async_pulses", {press_pulse, release_pulse, long_press}, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s6_no_release", release_pulse, 0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("s6_requal_button", button, k >= 7);
            chk("s6_requal_pulse", press_pulse, k == 7);
            chk("s6_release_never", release_pulse, 0);
        end
        chk("s6_requal_count", press_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
